rom_stream_reader: RTL and testbench

- Sequencer that sits directly upstream of the asynchronous single-port lookup ROM (addr in, data out, combinational read).
- On a start command it walks a contiguous address window, drives the ROM address, registers each returned word, and presents it downstream on a valid/ready stream with a last flag.
- Converts the ROM's random-access read port into a flow-controlled burst for consumers such as display or serializer stages.

---
 rtl/rom_stream_reader.sv | 146 ++++++++++++++
 tb/tb_rom_stream_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Burst sequencer for a combinational ROM; streams words out on valid/ready.
// Optional ROM_READER_CHECKSUM_EN adds a per-burst running checksum output.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
`ifdef ROM_READER_CHECKSUM_EN
    output logic [DATA_WIDTH+ADDR_WIDTH:0] checksum,
`endif
    output logic                  done
);

    localparam int CW = DATA_WIDTH + ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  final_word;
    logic                  hs;

`ifdef ROM_READER_CHECKSUM_EN
    logic [CW-1:0] csum_q, csum_d;
`endif

    assign final_word = (rem_q == (ADDR_WIDTH+1)'(1));
    assign hs         = valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
`ifdef ROM_READER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && (count != '0)) begin
                    addr_d  = start_addr;
                    rem_d   = count;
                    state_d = FETCH;
`ifdef ROM_READER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            FETCH: begin
                data_d  = rom_data;
                valid_d = 1'b1;
                last_d  = final_word;
                state_d = HOLD;
            end
            HOLD: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
                    csum_d  = csum_q + CW'(data_q);
`endif
                    if (final_word) begin
                        state_d = DONE;
                    end else begin
                        // address wraps naturally at 2^ADDR_WIDTH
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        rem_d   = rem_q - (ADDR_WIDTH+1)'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign rom_addr = addr_q;
    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign m_last   = last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a rom[i] = i mod 4 model.
// Checksum checks are compiled in when ROM_READER_CHECKSUM_EN is defined.
module tb_rom_stream_reader;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] count;
    logic [2:0] rom_addr;
    logic [1:0] rom_data;
    logic [1:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;
    logic       done;
`ifdef ROM_READER_CHECKSUM_EN
    logic [5:0] checksum;
`endif

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    rom_stream_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
`ifdef ROM_READER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    // ROM model: rom[i] = i mod 4
    assign rom_data = rom_addr[1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_valid && m_ready) hs_cnt = hs_cnt + 1;
    end

    typedef struct {
        bit       new_burst;
        bit [2:0] sa;
        bit [3:0] cnt;
        bit [2:0] e_addr;
        bit [1:0] e_data;
        bit       e_last;
    } vec_t;

    vec_t vecs[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_m_data"}, int'(m_data), 0);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_m_last"}, int'(m_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
`ifdef ROM_READER_CHECKSUM_EN
        check({tag, "_checksum"}, int'(checksum), 0);
`endif
    endtask

    initial begin
        // burst 2,3 -> addrs 2,3,4 data 2,3,0
        vecs[0]  = '{1'b1, 3'd2, 4'd3, 3'd2, 2'd2, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 4'd0, 3'd3, 2'd3, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 4'd0, 3'd4, 2'd0, 1'b1};
        // wrap: 6,4 -> addrs 6,7,0,1 data 2,3,0,1
        vecs[3]  = '{1'b1, 3'd6, 4'd4, 3'd6, 2'd2, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 4'd0, 3'd7, 2'd3, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 4'd0, 3'd0, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 4'd0, 3'd1, 2'd1, 1'b1};
        // count 10 > 8: addresses wrap and repeat
        vecs[7]  = '{1'b1, 3'd5, 4'd10, 3'd5, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 4'd0, 3'd6, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 4'd0, 3'd7, 2'd3, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 4'd0, 3'd0, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 4'd0, 3'd1, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 4'd0, 3'd2, 2'd2, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 4'd0, 3'd3, 2'd3, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 4'd0, 3'd4, 2'd0, 1'b0};
        vecs[15] = '{1'b0, 3'd0, 4'd0, 3'd5, 2'd1, 1'b0};
        vecs[16] = '{1'b0, 3'd0, 4'd0, 3'd6, 2'd2, 1'b1};

        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = 3'd0;
        count      = 4'd0;
        m_ready    = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // table-driven bursts with m_ready held high
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].new_burst) begin
                start      = 1'b1;
                start_addr = vecs[i].sa;
                count      = vecs[i].cnt;
                step();
                start = 1'b0;
                check($sformatf("v%0d_busy_after_start", i), int'(busy), 1);
                check($sformatf("v%0d_no_valid_yet", i), int'(m_valid), 0);
            end
            step();
            check($sformatf("v%0d_valid", i), int'(m_valid), 1);
            check($sformatf("v%0d_rom_addr", i), int'(rom_addr), int'(vecs[i].e_addr));
            check($sformatf("v%0d_m_data", i), int'(m_data), int'(vecs[i].e_data));
            check($sformatf("v%0d_m_last", i), int'(m_last), int'(vecs[i].e_last));
            check($sformatf("v%0d_no_done", i), int'(done), 0);
            step();
            check($sformatf("v%0d_valid_cleared", i), int'(m_valid), 0);
            if (vecs[i].e_last) begin
                check($sformatf("v%0d_done", i), int'(done), 1);
                check($sformatf("v%0d_busy_in_done", i), int'(busy), 1);
                step();
                check($sformatf("v%0d_done_clear", i), int'(done), 0);
                check($sformatf("v%0d_idle", i), int'(busy), 0);
            end else begin
                check($sformatf("v%0d_no_done_mid", i), int'(done), 0);
            end
        end

        // count = 0 is a no-op
        start      = 1'b1;
        start_addr = 3'd3;
        count      = 4'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cnt0_busy%0d", k), int'(busy), 0);
            check($sformatf("cnt0_done%0d", k), int'(done), 0);
            step();
        end

        // backpressure plus an ignored start mid-burst
        m_ready    = 1'b0;
        start      = 1'b1;
        start_addr = 3'd1;
        count      = 4'd2;
        step();
        start = 1'b0;
        begin
            int hs0;
            hs0 = hs_cnt;
            step();
            check("bp_first_valid", int'(m_valid), 1);
            start      = 1'b1;
            start_addr = 3'd7;
            count      = 4'd5;
            for (int k = 0; k < 5; k++) begin
                step();
                start = 1'b0;
                check($sformatf("bp_valid%0d", k), int'(m_valid), 1);
                check($sformatf("bp_data%0d", k), int'(m_data), 1);
                check($sformatf("bp_last%0d", k), int'(m_last), 0);
                check($sformatf("bp_addr%0d", k), int'(rom_addr), 1);
            end
            m_ready = 1'b1;
            step();
            check("bp_fetch2", int'(m_valid), 0);
            step();
            check("bp_w2_addr", int'(rom_addr), 2);
            check("bp_w2_data", int'(m_data), 2);
            check("bp_w2_last", int'(m_last), 1);
            step();
            check("bp_done", int'(done), 1);
            step();
            check("bp_idle", int'(busy), 0);
            check("bp_handshakes", hs_cnt - hs0, 2);
        end

        // reset during HOLD of word 2 of 4
        start      = 1'b1;
        start_addr = 3'd0;
        count      = 4'd4;
        step();
        start = 1'b0;
        step();
        step();
        m_ready = 1'b0;
        step();
        check("rst_w2_valid", int'(m_valid), 1);
        check("rst_w2_addr", int'(rom_addr), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        step();
        check("midrst_no_done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b1;
        step();
        check("post_rst_no_done", int'(done), 0);
        start      = 1'b1;
        start_addr = 3'd3;
        count      = 4'd1;
        step();
        start = 1'b0;
        step();
        check("post_rst_addr", int'(rom_addr), 3);
        check("post_rst_data", int'(m_data), 3);
        check("post_rst_last", int'(m_last), 1);
        step();
        check("post_rst_done", int'(done), 1);
        step();

`ifdef ROM_READER_CHECKSUM_EN
        start      = 1'b1;
        start_addr = 3'd0;
        count      = 4'd8;
        step();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 100) begin
                step();
                n++;
            end
            check("csum_done_seen", int'(done), 1);
        end
        check("csum_final", int'(checksum), 12);
        step();
        check("csum_held", int'(checksum), 12);
        start = 1'b1;
        count = 4'd1;
        step();
        start = 1'b0;
        check("csum_cleared", int'(checksum), 0);
        step();
        step();
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
